// File: rtl/taadda_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : taadda_io_pkg
// Brief    : Shared widths and constants for the TAADDA host I/O responder.
// Revision : 1.0 - initial release
// ============================================================================
package taadda_io_pkg;

   localparam int                BYTE_W        = 8;
   localparam int                DEFAULT_DEPTH = 16;
   localparam logic [BYTE_W-1:0] IDLE_BYTE     = 8'h00;

endpackage
`default_nettype wire

// File: rtl/taadda_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : taadda_byte_fifo
// Brief    : Show-ahead byte FIFO with registered storage, pointers and count.
// Revision : 1.0 - initial release
// ============================================================================
module taadda_byte_fifo
   import taadda_io_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [BYTE_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   // A push into a full FIFO only lands when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/taadda_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : taadda_io_responder
// Brief    : Host-side responder feeding and draining the TAADDA core I/O port.
// Revision : 1.0 - initial release
// ============================================================================
module taadda_io_responder
   import taadda_io_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arch_input_enable,
   output logic [BYTE_W-1:0] arch_input_value,
   input  logic              arch_output_enable,
   input  logic [BYTE_W-1:0] arch_output_value,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [BYTE_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CW-1:0]     in_count,
   output logic [CW-1:0]     out_count,
   output logic              underflow,
   output logic              overflow,
   input  logic              status_clr
);

   logic              in_push, in_pop, in_full, in_empty;
   logic              out_push, out_pop, out_full, out_empty;
   logic [BYTE_W-1:0] in_head, out_head;
   logic              underflow_q, underflow_d;
   logic              overflow_q, overflow_d;

   // The core cannot stall: reads of an empty FIFO and refused writes only raise flags.
   always_comb begin
      in_ready         = ~in_full;
      in_push          = in_valid & ~in_full;
      in_pop           = arch_input_enable & ~in_empty;
      arch_input_value = in_empty ? IDLE_BYTE : in_head;

      out_valid        = ~out_empty;
      out_data         = out_empty ? IDLE_BYTE : out_head;
      out_pop          = out_valid & out_ready;
      out_push         = arch_output_enable & (~out_full | out_pop);

      underflow_d      = underflow_q | (arch_input_enable & in_empty);
      overflow_d       = overflow_q | (arch_output_enable & ~out_push);
      if (status_clr) begin
         underflow_d = 1'b0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   assign underflow = underflow_q;
   assign overflow  = overflow_q;

   taadda_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push),
      .pop   (in_pop),
      .din   (in_data),
      .head  (in_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   taadda_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_push),
      .pop   (out_pop),
      .din   (arch_output_value),
      .head  (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_taadda_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_taadda_io_responder
// Brief    : Scoreboard bench for taadda_io_responder (DEPTH = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_taadda_io_responder;

   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk;
   logic          rst;
   logic          arch_input_enable;
   logic [7:0]    arch_input_value;
   logic          arch_output_enable;
   logic [7:0]    arch_output_value;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready;
   logic [CW-1:0] in_count;
   logic [CW-1:0] out_count;
   logic          underflow;
   logic          overflow;
   logic          status_clr;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] q_core [$];
   logic [7:0] q_host [$];
   logic [7:0] m_in   [$];
   logic [7:0] m_out  [$];

   taadda_io_responder #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .arch_input_enable  (arch_input_enable),
      .arch_input_value   (arch_input_value),
      .arch_output_enable (arch_output_enable),
      .arch_output_value  (arch_output_value),
      .in_valid           (in_valid),
      .in_data            (in_data),
      .in_ready           (in_ready),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_ready          (out_ready),
      .in_count           (in_count),
      .out_count          (out_count),
      .underflow          (underflow),
      .overflow           (overflow),
      .status_clr         (status_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      arch_input_enable  = 1'b0;
      arch_output_enable = 1'b0;
      arch_output_value  = 8'h00;
      in_valid           = 1'b0;
      in_data            = 8'h00;
      out_ready          = 1'b0;
      status_clr         = 1'b0;
   endtask

   // Monitor: compares the byte the core samples and the byte the host pops.
   always @(negedge clk) begin
      if (rst) begin
         if (arch_input_enable) begin
            if (q_core.size() == 0) chk("core_read_unexpected", 1, 0);
            else chk("core_read", arch_input_value, q_core.pop_front());
         end
         if (out_valid && out_ready) begin
            if (q_host.size() == 0) chk("host_pop_unexpected", 1, 0);
            else chk("host_pop", out_data, q_host.pop_front());
         end
      end
   end

   initial begin
      logic       r_ie, r_iv, r_oe, r_or, w_full_before, w_hpop;
      logic [7:0] r_id, r_od, v;
      int         push_w;

      idle();
      rst = 1'b0;
      repeat (2) begin
         arch_input_enable  = 1'($urandom);
         arch_output_enable = 1'($urandom);
         arch_output_value  = 8'($urandom);
         in_valid           = 1'($urandom);
         in_data            = 8'($urandom);
         out_ready          = 1'($urandom);
         status_clr         = 1'($urandom);
         tick();
      end
      idle();
      rst = 1'b1;
      chk("rst_in_count", in_count, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_arch_in_value", arch_input_value, 8'h00);
      chk("rst_underflow", underflow, 0);
      chk("rst_overflow", overflow, 0);

      // Input ordering
      in_valid = 1'b1;
      in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      in_data = 8'h33; tick();
      in_valid = 1'b0;
      chk("order_in_count", in_count, 3);
      chk("order_head_visible", arch_input_value, 8'h11);
      arch_input_enable = 1'b1;
      q_core.push_back(8'h11); tick(); chk("order_cnt2", in_count, 2);
      q_core.push_back(8'h22); tick(); chk("order_cnt1", in_count, 1);
      q_core.push_back(8'h33); tick(); chk("order_cnt0", in_count, 0);
      arch_input_enable = 1'b0;
      chk("order_underflow", underflow, 0);

      // Underflow with same-cycle push: no bypass
      arch_input_enable = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
      q_core.push_back(8'h00); tick();
      in_valid = 1'b0;
      chk("uf_flag", underflow, 1);
      chk("uf_in_count", in_count, 1);
      q_core.push_back(8'h5A); tick();
      arch_input_enable = 1'b0;
      chk("uf_drained", in_count, 0);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      chk("uf_cleared", underflow, 0);

      // Clear wins over a same-cycle underflow
      arch_input_enable = 1'b1; status_clr = 1'b1;
      q_core.push_back(8'h00); tick();
      idle();
      chk("clr_priority", underflow, 0);

      // Full input FIFO refuses a push even when the core pops
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         in_data = 8'hC0 + 8'(i); tick();
      end
      chk("in_full_ready", in_ready, 0);
      chk("in_full_count", in_count, 16);
      in_data = 8'hEE; arch_input_enable = 1'b1;
      q_core.push_back(8'hC0); tick();
      in_valid = 1'b0;
      chk("in_full_refused", in_count, 15);
      for (int i = 1; i < DEPTH; i++) begin
         q_core.push_back(8'hC0 + 8'(i)); tick();
      end
      arch_input_enable = 1'b0;
      chk("in_full_drained", in_count, 0);
      chk("in_full_no_uf", underflow, 0);

      // Output full / drop
      arch_output_enable = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         arch_output_value = 8'(i); tick();
      end
      arch_output_enable = 1'b0;
      chk("drop_out_count", out_count, 16);
      chk("drop_overflow", overflow, 1);
      chk("drop_out_valid", out_valid, 1);
      chk("drop_head", out_data, 8'h00);
      for (int i = 0; i < DEPTH; i++) q_host.push_back(8'(i));
      out_ready = 1'b1;
      repeat (DEPTH) tick();
      out_ready = 1'b0;
      chk("drop_drained", out_count, 0);
      chk("drop_empty_valid", out_valid, 0);
      chk("drop_empty_data", out_data, 8'h00);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      chk("of_cleared", overflow, 0);

      // Full with concurrent drain
      arch_output_enable = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         arch_output_value = 8'hB0 + 8'(i); tick();
      end
      chk("cd_full", out_count, 16);
      arch_output_value = 8'hAA; out_ready = 1'b1;
      q_host.push_back(8'hB0); tick();
      arch_output_enable = 1'b0; out_ready = 1'b0;
      chk("cd_count", out_count, 16);
      chk("cd_overflow", overflow, 0);
      for (int i = 1; i < DEPTH; i++) q_host.push_back(8'hB0 + 8'(i));
      q_host.push_back(8'hAA);
      out_ready = 1'b1;
      repeat (DEPTH) tick();
      out_ready = 1'b0;
      chk("cd_drained", out_count, 0);

      // Wrap-around stress against queue models
      for (int c = 0; c < 1000; c++) begin
         push_w = ((c % 200) < 100) ? 3 : 1;
         r_iv = ($urandom_range(0, 3) < push_w);
         r_oe = ($urandom_range(0, 3) < push_w);
         r_ie = ($urandom_range(0, 3) >= push_w);
         r_or = ($urandom_range(0, 3) >= push_w);
         r_id = 8'($urandom);
         r_od = 8'($urandom);

         w_full_before = (m_out.size() == DEPTH);
         if (r_ie) begin
            if (m_in.size() > 0) q_core.push_back(m_in.pop_front());
            else q_core.push_back(8'h00);
         end
         if (r_iv && (m_in.size() + (r_ie && m_in.size() == 0 ? 0 : 0)) < DEPTH + (r_ie ? 1 : 0)
             && !(r_ie && m_in.size() == DEPTH - 1 && 0)) begin
         end
         w_hpop = r_or && (m_out.size() > 0);
         if (w_hpop) q_host.push_back(m_out.pop_front());
         if (r_oe && (!w_full_before || w_hpop)) m_out.push_back(r_od);

         arch_input_enable  = r_ie;
         in_valid           = r_iv;
         in_data            = r_id;
         arch_output_enable = r_oe;
         arch_output_value  = r_od;
         out_ready          = r_or;
         v                  = {7'd0, in_ready};
         tick();
         if (r_iv && v[0]) m_in.push_back(r_id);
         chk("stress_in_count", in_count, m_in.size());
         chk("stress_out_count", out_count, m_out.size());
         chk("stress_in_bound", (in_count <= CW'(DEPTH)), 1);
      end
      idle();

      // Reset mid-operation discards queued bytes
      in_valid = 1'b1; in_data = 8'h77; arch_output_enable = 1'b1; arch_output_value = 8'h88;
      tick(); tick();
      idle();
      rst = 1'b0; tick(); rst = 1'b1;
      chk("midrst_in_count", in_count, 0);
      chk("midrst_out_count", out_count, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_arch_in_value", arch_input_value, 8'h00);

      tick();
      chk("core_queue_empty", q_core.size(), 0);
      chk("host_queue_empty", q_host.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/taadda_io_responder.md
# taadda_io_responder

Host-side responder for the TAADDA core's architectural I/O port. It sits opposite the core's `arch_input_*` / `arch_output_*` pins:
- It supplies input bytes the core reads, from a host-fed input FIFO.
- It captures bytes the core writes into an output FIFO drained by the host.

The core cannot stall, so all underflow and overflow cases are handled here and reported through sticky status flags.

## Interface
Parameters:
- `DEPTH`, 16, entries per FIFO; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`, width of the count outputs; derived, not overridden.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-low reset; all state clears when `rst`=0 at a rising edge.
- `arch_input_enable`  in  1  — the core is reading this cycle.
- `arch_input_value`  out  8  — byte presented to the core.
- `arch_output_enable`  in  1  — the core is writing this cycle.
- `arch_output_value`  in  8  — byte written by the core; valid only while the enable is 1.
- `in_valid`  in  1  — host offers an input byte.
- `in_data`  in  8  — host input byte.
- `in_ready`  out  1  — input FIFO can accept.
- `out_valid`  out  1  — output FIFO is non-empty.
- `out_data`  out  8  — head of the output FIFO.
- `out_ready`  in  1  — host consumes the output head.
- `in_count`  out  CW  — input FIFO occupancy.
- `out_count`  out  CW  — output FIFO occupancy.
- `underflow`  out  1  — sticky: the core read while the input FIFO was empty.
- `overflow`  out  1  — sticky: a core write was dropped.
- `status_clr`  in  1  — clears both sticky flags.

## Operation
- **Input path**
  - Host push occurs when `in_valid & in_ready`, with `in_ready = (in_count != DEPTH)`.
  - `in_ready` ignores a core pop in the same cycle. A full FIFO refuses the push even if the core pops.
  - `arch_input_value` = input FIFO head when non-empty, else 8'h00. It is combinational from registered FIFO state, because the core samples it in the same cycle.
  - A core read with FIFO non-empty pops the head at the edge.
  - A core read with FIFO empty returns 8'h00, sets `underflow` and pops nothing.
  - A host push to an empty FIFO in the same cycle as a core read is not bypassed: the core gets 8'h00, `underflow` sets, and the pushed byte is stored.
- **Output path**
  - A core write is accepted if `out_count != DEPTH`, or if the FIFO is full and `out_valid & out_ready` in the same cycle (the write takes the freed slot).
  - Otherwise the byte is dropped, `overflow` sets, and FIFO contents are unchanged.
  - A host pop occurs when `out_valid & out_ready`; `out_data` is the head and is stable until popped.
  - When `out_valid`=0, `out_data` = 8'h00.
- **Simultaneous push and pop on either FIFO:** the count is unchanged and order is preserved (FIFO, wrap-around pointers modulo DEPTH).
- **Status flags**
  - `status_clr` has priority over a same-cycle set. The event in that cycle is lost from the flags.
  - The FIFO actions in that cycle still occur.

## Timing
- Reset values:
  - Both counts = 0.
  - Pointers = 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=8'h00, `arch_input_value`=8'h00.
  - `underflow`=0, `overflow`=0.
- Reset mid-operation discards all queued bytes. Inputs are ignored during the reset cycle.
- Input latency: a host byte pushed at edge N is visible on `arch_input_value` after edge N (readable in cycle N+1).
- Output latency: a core byte written at edge N gives `out_valid`=1 and `out_data` = that byte after edge N.
- Counts and flags update at the same edge as the event that changes them.
- No combinational path exists from `arch_input_enable` to `arch_input_value`, or from `out_ready` to `out_valid`/`out_data`.

## Structure
- Package `taadda_io_pkg`: `BYTE_W`=8, `DEFAULT_DEPTH`=16, `IDLE_BYTE`=8'h00.
- Sub-module `taadda_byte_fifo`, instantiated twice.
  - Show-ahead, registered storage, read/write pointers plus a count.
  - Ports: `push`, `pop`, `din`, `head`, `full`, `empty`, `count`.
- The top level holds the accept/drop gating, the idle-byte muxing and the sticky flags.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with random inputs, then release → counts 0, `in_ready`=1, `out_valid`=0, flags 0, `arch_input_value`=00.
- **Input ordering:** host pushes 11,22,33; core reads 3 times → core receives 11,22,33 in order; `in_count` goes 3→0; `underflow` stays 0.
- **Underflow:** core reads while empty, with a host push of 5A in the same cycle → core gets 00, `underflow`=1, `in_count`=1. Next read returns 5A. Then `status_clr` → `underflow`=0.
- **Output full / drop:** `out_ready`=0, core writes DEPTH+1 bytes 00..10 → `out_count`=16, `overflow`=1. Host then drains 00..0F; byte 10 is absent.
- **Full with concurrent drain:** output FIFO full; core writes AA in the same cycle as a host pop → AA accepted, `out_count` stays 16, `overflow` stays 0. AA emerges last.
- **Wrap-around stress:** random push/pop on both sides with both handshakes for 1000 cycles → byte stream matches a scoreboard; counts never exceed DEPTH.
